// File: rtl/program_loader.sv
// Serial program loader: length byte, then 4*N bytes MSB first, packed into 32-bit words
// and strobed into the CPU instruction memory. The CPU is then started.
// Ports:
//   clk, rst (async, active-low)
//   byte_in/byte_valid/byte_ready  byte stream handshake
//   clear                          leave DONE/ERR for LEN
//   next_instruction, mem_write    word and write strobe to the CPU load port
//   cpu_rst, start                 one-cycle pulses to the CPU
//   busy, done, error, words_loaded  status
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum byte after the data).
module program_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   input  logic        clear,
   output logic [31:0] next_instruction,
   output logic        mem_write,
   output logic        cpu_rst,
   output logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [4:0]  words_loaded
);

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_WRITE,
      S_GAP,
      S_CHK,
      S_START,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state;
   logic [4:0]  n_len;
   logic [1:0]  idx;
   logic [23:0] shift_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   logic accept;

   assign byte_ready = (state == S_LEN) || (state == S_DATA) ||
                       (state == S_CHK);
   assign busy       = !((state == S_LEN) || (state == S_DONE) ||
                         (state == S_ERR));
   assign accept     = byte_valid && byte_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= S_LEN;
         n_len            <= '0;
         idx              <= '0;
         shift_q          <= '0;
         next_instruction <= '0;
         mem_write        <= 1'b0;
         cpu_rst          <= 1'b0;
         start            <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         words_loaded     <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum             <= '0;
`endif
      end else begin
         cpu_rst   <= 1'b0;
         mem_write <= 1'b0;
         start     <= 1'b0;
         unique case (state)
            S_LEN: begin
               if (accept) begin
                  if (byte_in != 8'd0 && byte_in <= 8'd16) begin
                     n_len        <= byte_in[4:0];
                     cpu_rst      <= 1'b1;
                     words_loaded <= '0;
                     idx          <= '0;
`ifdef LOADER_CHECKSUM_EN
                     csum         <= '0;
`endif
                     state        <= S_DATA;
                  end else begin
                     error <= 1'b1;
                     state <= S_ERR;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  idx <= idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum <= csum ^ byte_in;
`endif
                  // Word register only updates on the 4th byte, so the
                  // value seen by the CPU is stable across the strobe.
                  if (idx == 2'd3) begin
                     next_instruction <= {shift_q, byte_in};
                     mem_write        <= 1'b1;
                     state            <= S_WRITE;
                  end else begin
                     shift_q <= {shift_q[15:0], byte_in};
                  end
               end
            end
            S_WRITE: begin
               if (words_loaded != 5'd16)
                  words_loaded <= words_loaded + 5'd1;
               state <= S_GAP;
            end
            S_GAP: begin
               if (words_loaded < n_len) begin
                  state <= S_DATA;
               end else begin
`ifdef LOADER_CHECKSUM_EN
                  state <= S_CHK;
`else
                  start <= 1'b1;
                  state <= S_START;
`endif
               end
            end
            S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
               if (accept) begin
                  if (byte_in == csum) begin
                     start <= 1'b1;
                     state <= S_START;
                  end else begin
                     error <= 1'b1;
                     state <= S_ERR;
                  end
               end
`else
               error <= 1'b1;
               state <= S_ERR;
`endif
            end
            S_START: begin
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE, S_ERR: begin
               if (clear) begin
                  done         <= 1'b0;
                  error        <= 1'b0;
                  words_loaded <= '0;
                  state        <= S_LEN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected words are queued as bytes
// are driven and popped on each mem_write strobe.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        clear;
   logic [31:0] next_instruction;
   logic        mem_write;
   logic        cpu_rst;
   logic        start;
   logic        busy;
   logic        done;
   logic        error;
   logic [4:0]  words_loaded;

   always #5 clk = ~clk;

   program_loader dut (
      .clk              (clk),
      .rst              (rst),
      .byte_in          (byte_in),
      .byte_valid       (byte_valid),
      .byte_ready       (byte_ready),
      .clear            (clear),
      .next_instruction (next_instruction),
      .mem_write        (mem_write),
      .cpu_rst          (cpu_rst),
      .start            (start),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .words_loaded     (words_loaded)
   );

   int n_checks = 0;
   int n_errors = 0;
   int mw_cnt = 0;
   int cr_cnt = 0;
   int st_cnt = 0;
   logic mw_prev = 1'b0;
   logic [31:0] sb_q[$];
   logic [31:0] prog[16];
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] cs_acc;
`endif

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_write) begin
         mw_cnt++;
         check("mw_low_gap", {31'b0, mw_prev}, 32'd0);
         if (sb_q.size() == 0)
            check("sb_extra_write", 32'd1, 32'd0);
         else
            check("instr", next_instruction, sb_q.pop_front());
      end
      if (cpu_rst) cr_cnt++;
      if (start) st_cnt++;
      mw_prev = mem_write;
   end

   // Called at a negedge; leaves byte_valid high so the bench also
   // exercises bytes offered while the loader is not ready.
   task automatic send(input logic [7:0] b);
      int t = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check("send_timeout", 32'd0, 32'd1);
      else @(negedge clk);
   endtask

   task automatic begin_stream(input int n);
`ifdef LOADER_CHECKSUM_EN
      cs_acc = 8'h00;
`endif
      send(n[7:0]);
   endtask

   task automatic send_word(input logic [31:0] w);
      sb_q.push_back(w);
      for (int k = 0; k < 4; k++) begin
         logic [7:0] b;
         b = w[31-8*k -: 8];
`ifdef LOADER_CHECKSUM_EN
         cs_acc = cs_acc ^ b;
`endif
         send(b);
      end
   endtask

   task automatic load(input int n);
      begin_stream(n);
      for (int i = 0; i < n; i++) send_word(prog[i]);
   endtask

   task automatic tail();
`ifdef LOADER_CHECKSUM_EN
      send(cs_acc);
`endif
   endtask

   task automatic wait_end();
      int t = 0;
      while (!(done || error) && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("end_timeout", {31'b0, (t >= 300)}, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_clear();
      byte_valid = 1'b0;
      clear      = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      check("clr_ready", {31'b0, byte_ready}, 32'd1);
      check("clr_wl", {27'b0, words_loaded}, 32'd0);
      check("clr_flags", {30'b0, done, error}, 32'd0);
   endtask

   initial begin
      int mw0, cr0, st0;
      logic [7:0] bad_len[2];
      rst        = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      clear      = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", {31'b0, byte_ready}, 32'd1);
      check("rst_instr", next_instruction, 32'd0);
      check("rst_strobes", {29'b0, mem_write, cpu_rst, start}, 32'd0);
      check("rst_status", {29'b0, busy, done, error}, 32'd0);
      check("rst_wl", {27'b0, words_loaded}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rel_ready", {31'b0, byte_ready}, 32'd1);

      // single word; byte_valid stays high through START/DONE
      mw0 = mw_cnt; cr0 = cr_cnt; st0 = st_cnt;
      prog[0] = 32'h12345678;
      load(1);
      tail();
      wait_end();
      repeat (4) @(negedge clk);
      check("t1_done", {31'b0, done}, 32'd1);
      check("t1_wl", {27'b0, words_loaded}, 32'd1);
      check("t1_cpu_rst", cr_cnt - cr0, 32'd1);
      check("t1_writes", mw_cnt - mw0, 32'd1);
      check("t1_start", st_cnt - st0, 32'd1);
      do_clear();

      // 16 words back-to-back
      mw0 = mw_cnt; cr0 = cr_cnt; st0 = st_cnt;
      for (int i = 0; i < 16; i++) prog[i] = $urandom;
      load(16);
      tail();
      wait_end();
      check("t2_done", {31'b0, done}, 32'd1);
      check("t2_wl", {27'b0, words_loaded}, 32'd16);
      check("t2_writes", mw_cnt - mw0, 32'd16);
      check("t2_start", st_cnt - st0, 32'd1);
      check("t2_cpu_rst", cr_cnt - cr0, 32'd1);
      do_clear();

      // illegal lengths
      bad_len[0] = 8'h00;
      bad_len[1] = 8'h11;
      for (int i = 0; i < 2; i++) begin
         mw0 = mw_cnt; cr0 = cr_cnt; st0 = st_cnt;
         send(bad_len[i]);
         wait_end();
         check("t3_error", {31'b0, error}, 32'd1);
         check("t3_ready", {31'b0, byte_ready}, 32'd0);
         check("t3_pulses", (mw_cnt - mw0) + (cr_cnt - cr0) + (st_cnt - st0),
               32'd0);
         do_clear();
         check("t3_busy", {31'b0, busy}, 32'd0);
      end

`ifdef LOADER_CHECKSUM_EN
      // good and bad checksum
      for (int i = 0; i < 2; i++) begin
         mw0 = mw_cnt; st0 = st_cnt;
         prog[0] = 32'hAA550FF0;
         load(1);
         send(i[7:0]);
         wait_end();
         check("t4_writes", mw_cnt - mw0, 32'd1);
         check("t4_start", st_cnt - st0, (i == 0) ? 32'd1 : 32'd0);
         check("t4_result", {30'b0, done, error}, (i == 0) ? 32'd2 : 32'd1);
         do_clear();
      end
`endif

      // clear during DATA is ignored
      prog[0] = 32'hCAFEF00D;
      prog[1] = 32'h0BADBEEF;
      begin_stream(2);
      sb_q.push_back(prog[0]);
      send(prog[0][31:24]);
      send(prog[0][23:16]);
`ifdef LOADER_CHECKSUM_EN
      cs_acc = prog[0][31:24] ^ prog[0][23:16];
`endif
      byte_valid = 1'b0;
      clear      = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      check("t5_busy", {31'b0, busy}, 32'd1);
      check("t5_ready", {31'b0, byte_ready}, 32'd1);
      send(prog[0][15:8]);
      send(prog[0][7:0]);
`ifdef LOADER_CHECKSUM_EN
      cs_acc = cs_acc ^ prog[0][15:8] ^ prog[0][7:0];
`endif
      send_word(prog[1]);
      tail();
      wait_end();
      check("t5_done", {31'b0, done}, 32'd1);
      check("t5_wl", {27'b0, words_loaded}, 32'd2);
      do_clear();

      // reset during WRITE of word 2 of 3
      prog[0] = 32'h11112222;
      prog[1] = 32'h33334444;
      begin_stream(3);
      send_word(prog[0]);
      send_word(prog[1]);
      check("t6_in_write", {31'b0, mem_write}, 32'd1);
      #2;
      rst        = 1'b0;
      byte_valid = 1'b0;
      #1;
      check("t6_async_mw", {31'b0, mem_write}, 32'd0);
      check("t6_busy", {31'b0, busy}, 32'd0);
      check("t6_wl", {27'b0, words_loaded}, 32'd0);
      check("t6_instr", next_instruction, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_ready", {31'b0, byte_ready}, 32'd1);
      mw0 = mw_cnt;
      prog[0] = 32'hDEADC0DE;
      load(1);
      tail();
      wait_end();
      check("t6_done", {31'b0, done}, 32'd1);
      check("t6_writes", mw_cnt - mw0, 32'd1);
      check("t6_wl2", {27'b0, words_loaded}, 32'd1);
      do_clear();

      check("sb_empty", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- byte_in  input  8  serial program byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader accepts byte; transfer when byte_valid and byte_ready are both high on a clk edge.
- clear  input  1  return from DONE/ERR to LEN.
- next_instruction  output  32  assembled instruction word to the CPU instruction-memory load port.
- mem_write  output  1  write strobe; the CPU advances its load address on each rising edge of this strobe.
- cpu_rst  output  1  one-cycle high pulse that zeroes the CPU load counter.
- start  output  1  one-cycle high pulse that hands control to the CPU.
- busy  output  1  high in any state other than LEN, DONE or ERR.
- done  output  1  high in DONE.
- error  output  1  high in ERR.
- words_loaded  output  5  count of words strobed, 0..16.

Function
REQ-002 SHALL implement states LEN, DATA, WRITE, GAP, CHK, START, DONE, ERR.
REQ-003 Stream format SHALL be: length byte N, then 4*N data bytes, most significant byte first, then an optional checksum byte (see Configuration).
REQ-004 byte_ready SHALL be high in LEN, DATA and CHK, and low in all other states.
REQ-005 LEN, on accepting a byte with value 1..16:
- latch N;
- pulse cpu_rst for one cycle;
- clear words_loaded, byte index and checksum;
- go to DATA.
REQ-006 LEN, on accepting value 0 or a value >16: go to ERR; cpu_rst stays low.
REQ-007 DATA SHALL shift each accepted byte into the word register, index 0 into bits 31:24 through index 3 into bits 7:0.
REQ-008 When the 4th byte is accepted in DATA, the state SHALL go to WRITE on the next edge.
REQ-009 WRITE: mem_write=1 for exactly one cycle; words_loaded increments by 1 on exit; next state is GAP.
REQ-010 GAP: mem_write=0 for exactly one cycle, guaranteeing a low phase between strobes.
- Exit to DATA if words_loaded < N.
- Otherwise exit to CHK when LOADER_CHECKSUM_EN is defined, else to START.
REQ-011 next_instruction SHALL hold its value from WRITE entry until the next data byte is accepted; it never changes while mem_write=1.
REQ-012 START: start=1 for exactly one cycle, then go to DONE.
REQ-013 DONE and ERR SHALL hold until clear=1, then go to LEN with words_loaded cleared.
REQ-014 clear SHALL be ignored in all other states.
REQ-015 byte_valid without byte_ready SHALL be ignored; the byte is not consumed.
REQ-016 Back-to-back bytes (byte_valid continuously high) SHALL be accepted one per cycle in DATA; worst-case throughput is one word per 6 cycles.
REQ-017 words_loaded SHALL saturate at 16 and never wrap.

Reset
REQ-018 While rst=0, the block SHALL asynchronously force:
- state to LEN;
- next_instruction, mem_write, cpu_rst, start, done, error to 0;
- words_loaded, N, byte index and checksum to 0.
REQ-019 byte_ready SHALL be 1 after reset release.
REQ-020 Reset asserted mid-load or mid-strobe SHALL drop mem_write immediately and discard the partial word.

Configuration
REQ-021 Macro LOADER_CHECKSUM_EN, when defined:
- a running XOR is kept over all 4*N data bytes;
- CHK accepts one byte;
- if the byte equals the XOR, go to START; otherwise go to ERR, and start never pulses.
REQ-022 Without LOADER_CHECKSUM_EN: CHK is unreachable, no checksum byte is expected, and GAP after the last word goes directly to START.

Verification
REQ-023 Bench SHALL cover the following scenarios:
- Stream 01,12,34,56,78 with no macro -> cpu_rst pulse; one mem_write pulse with next_instruction=0x12345678; start pulse; done=1; words_loaded=1.
- N=16, 64 bytes, byte_valid held high -> 16 mem_write pulses each separated by a low cycle; words_loaded=16; start pulses once.
- Length byte 00 or 11h -> error=1, no cpu_rst, mem_write or start; clear -> byte_ready=1 in LEN.
- With LOADER_CHECKSUM_EN: 01,AA,55,0F,F0 then checksum 00 -> start; the same stream with checksum 01 -> error=1, no start.
- rst=0 asserted during WRITE of word 2 of N=3 -> mem_write drops asynchronously; after release, a new 01 stream loads correctly.
- byte_valid pulsed during WRITE/GAP/START/DONE -> byte not consumed; clear during DATA -> ignored.
